// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Time-multiplexed scan controller for a four-digit seven-segment display.
// A prescaler divides clk into digit slots. The digit index walks 0,1,2,3.
// Display data is double-buffered: loads land in a holding register and are
// promoted into the shadow registers only at a frame boundary, so one frame
// never shows a mix of old and new digits.
//
// Ports
//   clk          system clock; all state updates on its rising edge
//   reset        asynchronous, active-high reset
//   value_in     four hex digits; digit k = value_in[4k+3:4k], digit 0 rightmost
//   blank_in     per-digit blank enable (1 = digit dark)
//   blink_in     per-digit blink enable
//   load         single-cycle request to take value_in/blank_in/blink_in
//   load_ack     one-cycle pulse when the requested data becomes visible
//   hex_out      nibble of the active digit, for the hex-to-7-segment decoder
//   an           active-low digit anodes
//   frame_start  one-cycle pulse in the first cycle of each scan frame
//
// Digit scan FSM
//   state | meaning
//   DIG0  | digit 0 (rightmost) active, first slot of a frame
//   DIG1  | digit 1 active
//   DIG2  | digit 2 active
//   DIG3  | digit 3 active; its last cycle is the frame boundary
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  blink_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  hex_out,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      idx;

    logic [CW-1:0]   cnt;
    logic            tick;
    logic            boundary;

    logic [FW-1:0]   fc;
    logic            blink_phase;

    logic            pending;
    logic [15:0]     hold_value;
    logic [3:0]      hold_blank;
    logic [3:0]      hold_blink;

    logic [15:0]     shadow_value;
    logic [3:0]      shadow_blank;
    logic [3:0]      shadow_blink;

    logic            dark;

    // With PRESCALE=1 the counter never leaves 0, so tick is constant high.
    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (state == DIG3);
    assign idx      = state;

    // Prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Scan FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DIG0;
        end else begin
            state <= state_next;
        end
    end

    // Scan FSM: next state
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                DIG0:    state_next = DIG1;
                DIG1:    state_next = DIG2;
                DIG2:    state_next = DIG3;
                DIG3:    state_next = DIG0;
                default: state_next = DIG0;
            endcase
        end
    end

    // Scan FSM: outputs, decoded from registered state only
    always_comb begin
        hex_out = shadow_value[{idx, 2'b00} +: 4];
        dark    = shadow_blank[idx] | (shadow_blink[idx] & blink_phase);
        an      = 4'b1111;
        if (!dark) begin
            an = ~(4'b0001 << idx);
        end
    end

    // Frame counter and blink phase; the phase flips on the wrapping boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc          <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (fc == FC_MAX) begin
                fc          <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
        end
    end

    // Load path. A load on the boundary cycle bypasses the holding register
    // and wins over anything still pending from earlier in the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= 1'b0;
            hold_value   <= 16'h0000;
            hold_blank   <= 4'h0;
            hold_blink   <= 4'h0;
            shadow_value <= 16'h0000;
            shadow_blank <= 4'hF;
            shadow_blink <= 4'h0;
            load_ack     <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (boundary) begin
                if (load) begin
                    shadow_value <= value_in;
                    shadow_blank <= blank_in;
                    shadow_blink <= blink_in;
                    pending      <= 1'b0;
                    load_ack     <= 1'b1;
                end else if (pending) begin
                    shadow_value <= hold_value;
                    shadow_blank <= hold_blank;
                    shadow_blink <= hold_blink;
                    pending      <= 1'b0;
                    load_ack     <= 1'b1;
                end
            end else if (load) begin
                hold_value <= value_in;
                hold_blank <= blank_in;
                hold_blink <= blink_in;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Self-checking bench for sseg_scan_ctrl with PRESCALE=4, BLINK_FRAMES=2.
// The reference model works from elapsed cycles since reset release: the
// active digit, frame boundaries and blink phase are plain arithmetic on that
// count, and display data is tracked as "latest request since last boundary".
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    localparam int P  = 4;
    localparam int BF = 2;
    localparam int FR = 4 * P;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    // model state
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_blank;
    logic [3:0]  m_blink;
    logic        m_req;
    logic [15:0] r_val;
    logic [3:0]  r_blank;
    logic [3:0]  r_blink;
    logic        exp_ack;

    int ack_cnt;
    int fs_cnt;
    int dig3_lit;

    sseg_scan_ctrl #(
        .PRESCALE    (P),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .load       (load),
        .load_ack   (load_ack),
        .hex_out    (hex_out),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t n=%0d)", tag, obs, exp, $time, n);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        m_val   = 16'h0000;
        m_blank = 4'hF;
        m_blink = 4'h0;
        m_req   = 1'b0;
        r_val   = 16'h0000;
        r_blank = 4'h0;
        r_blink = 4'h0;
        exp_ack = 1'b0;
    endtask

    // One clock cycle: drive inputs, let the edge happen, compare all outputs.
    task automatic step(input logic ld, input logic [15:0] v,
                        input logic [3:0] bl, input logic [3:0] bk);
        logic       at_boundary;
        int         idx;
        logic       phase;
        logic [3:0] exp_an;
        load     = ld;
        value_in = v;
        blank_in = bl;
        blink_in = bk;
        // The last cycle of every frame is the boundary.
        at_boundary = ((n % FR) == FR - 1);
        if (ld) begin
            m_req   = 1'b1;
            r_val   = v;
            r_blank = bl;
            r_blink = bk;
        end
        exp_ack = 1'b0;
        if (at_boundary && m_req) begin
            m_val   = r_val;
            m_blank = r_blank;
            m_blink = r_blink;
            m_req   = 1'b0;
            exp_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        n++;
        idx   = (n / P) % 4;
        phase = ((n / (FR * BF)) % 2) == 1;
        exp_an = 4'b1111;
        if (!(m_blank[idx] || (m_blink[idx] && phase))) begin
            exp_an[idx] = 1'b0;
        end
        check("an", {12'h0, an}, {12'h0, exp_an});
        check("hex_out", {12'h0, hex_out}, {12'h0, m_val[idx*4 +: 4]});
        check("load_ack", {15'h0, load_ack}, {15'h0, exp_ack});
        check("frame_start", {15'h0, frame_start}, {15'h0, ((n % FR) == 0)});
        if (load_ack)    ack_cnt++;
        if (frame_start) fs_cnt++;
        if (!an[3])      dig3_lit++;
        load = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask

    // Advance until the model cycle count sits at the given frame position.
    task automatic advance_to(input int pos);
        for (int i = 0; i < FR && (n % FR) != pos; i++) begin
            step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask

    // Asserted away from the clock edge so the asynchronous response is visible.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_an", {12'h0, an}, 16'h000F);
        check("rst_async_ack", {15'h0, load_ack}, 16'h0000);
        check("rst_async_hex", {12'h0, hex_out}, 16'h0000);
        check("rst_async_fs", {15'h0, frame_start}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_an", {12'h0, an}, 16'h000F);
        check("rst_hold_hex", {12'h0, hex_out}, 16'h0000);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        blank_in = 4'h0;
        blink_in = 4'h0;
        ack_cnt  = 0;
        fs_cnt   = 0;
        dig3_lit = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // No load: dark display, frame_start every FR cycles.
        fs_cnt = 0;
        idle(3 * FR);
        check("idle_frame_starts", 16'(fs_cnt), 16'd3);
        check("idle_no_ack", 16'(ack_cnt), 16'd0);

        // Mid-frame load shows up at the next boundary with a single ack.
        advance_to(5);
        ack_cnt = 0;
        step(1'b1, 16'h1A2F, 4'h0, 4'h0);
        check("mid_load_no_early_ack", 16'(ack_cnt), 16'd0);
        advance_to(0);
        check("mid_load_ack_at_boundary", {15'h0, load_ack}, 16'h0001);
        check("mid_load_first_hex", {12'h0, hex_out}, 16'h000F);
        idle(2 * FR);
        check("mid_load_single_ack", 16'(ack_cnt), 16'd1);

        // Two loads in one frame: one ack, last value only.
        advance_to(2);
        ack_cnt = 0;
        step(1'b1, 16'h1111, 4'h0, 4'h0);
        idle(3);
        step(1'b1, 16'h2222, 4'h0, 4'h0);
        advance_to(0);
        idle(2 * FR);
        check("double_load_single_ack", 16'(ack_cnt), 16'd1);

        // Load on the boundary cycle itself, with an older request pending.
        advance_to(9);
        step(1'b1, 16'h7777, 4'h0, 4'h0);
        advance_to(FR - 1);
        ack_cnt = 0;
        step(1'b1, 16'h00C3, 4'h0, 4'h0);
        check("bnd_load_hex", {12'h0, hex_out}, 16'h0003);
        check("bnd_load_ack", {15'h0, load_ack}, 16'h0001);
        idle(2 * FR);
        check("bnd_load_single_ack", 16'(ack_cnt), 16'd1);

        // Blink digit 0, blank digit 3.
        advance_to(3);
        step(1'b1, 16'h4321, 4'b1000, 4'b0001);
        advance_to(0);
        dig3_lit = 0;
        idle(6 * FR);
        check("blank_dig3_never_lit", 16'(dig3_lit), 16'd0);

        // Reset while idx==2 with a request pending: no ack afterwards.
        advance_to(8);
        step(1'b1, 16'hBEEF, 4'h0, 4'h0);
        check("pre_reset_an_dig2", {12'h0, an}, 16'h000B);
        do_reset();
        ack_cnt = 0;
        idle(2 * FR);
        check("reset_discards_pending", 16'(ack_cnt), 16'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100000, meaning clock cycles per digit slot (legal range >= 1).
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 128, meaning full scan frames per blink half-period (legal range >= 1).
REQ-003 The block SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port value_in  input  16  four hex digits; digit k is value_in[4k+3:4k], with digit 0 rightmost.
REQ-006 The block SHALL have port blank_in  input  4  per-digit blank enable; 1 = digit dark.
REQ-007 The block SHALL have port blink_in  input  4  per-digit blink enable.
REQ-008 The block SHALL have port load  input  1  single-cycle request to take value_in, blank_in and blink_in.
REQ-009 The block SHALL have port load_ack  output  1  one-cycle pulse when the requested data becomes visible.
REQ-010 The block SHALL have port hex_out  output  4  nibble of the active digit, fed to the hex-to-7-segment decoder.
REQ-011 The block SHALL have port an  output  4  active-low digit anodes.
REQ-012 The block SHALL have port frame_start  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-013 Prescaler cnt SHALL count 0..PRESCALE-1, wrap to 0, and assert internal tick in the cycle where cnt == PRESCALE-1; with PRESCALE=1, tick SHALL be asserted every cycle.
REQ-014 Digit index idx (2 bits) SHALL advance on tick in the sequence 0,1,2,3,0, wrapping from 3 to 0.
REQ-015 Frame boundary SHALL be defined as tick with idx==3; frame_start SHALL be a registered pulse high for exactly the one cycle after each boundary edge, i.e. the first cycle with idx==0.
REQ-016 hex_out SHALL equal the shadow-value nibble selected by idx, decoded combinationally from registered state.
REQ-017 an SHALL have exactly bit idx low when that digit is visible and all other bits high; an SHALL be 4'b1111 when the active digit is blanked, or has blink set while blink_phase==1.
REQ-018 Frame counter fc SHALL count boundaries 0..BLINK_FRAMES-1 and wrap; blink_phase SHALL toggle on the boundary where fc wraps.
REQ-019 A cycle with load high and no boundary SHALL capture value_in, blank_in and blink_in into a holding register and set pending.
REQ-020 On a boundary edge with pending set, the shadow registers SHALL take the holding register, pending SHALL clear, and load_ack SHALL be high for the following single cycle.
REQ-021 A load while pending is already set SHALL overwrite the holding register; only the last request is displayed, and a single load_ack is produced.
REQ-022 A load coincident with a boundary SHALL write the inputs of that cycle directly into the shadow registers and pulse load_ack in the next cycle, taking priority over any older holding contents.
REQ-023 Shadow contents SHALL change only at a boundary, so a frame never shows mixed old and new digits.
REQ-024 load_ack and frame_start SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 While reset is high the block SHALL hold cnt=0, idx=0, fc=0, blink_phase=0, pending=0, holding=0, shadow value=16'h0000, shadow blank=4'hF, shadow blink=4'h0, load_ack=0 and frame_start=0; outputs SHALL therefore be an=4'b1111 and hex_out=4'h0.
REQ-026 Reset asserted mid-frame or while pending SHALL discard the pending request without producing a load_ack.
REQ-027 After reset deasserts, the first tick SHALL occur PRESCALE cycles later.

Verification (PRESCALE=4, BLINK_FRAMES=2)
REQ-028 Bench SHALL release reset, then apply no load -> an=1111 throughout, and frame_start pulses every 16 cycles.
REQ-029 Bench SHALL pulse load with value_in=16'h1A2F, blank_in=0 and blink_in=0 mid-frame -> at the next boundary load_ack pulses once, and the scan shows hex_out F,2,A,1 with an=1110,1101,1011,0111, 4 cycles each.
REQ-030 Bench SHALL issue two loads, 16'h1111 then 16'h2222, within one frame -> a single load_ack, and the display shows 2222 only.
REQ-031 Bench SHALL pulse load exactly on a boundary cycle with value_in=16'h00C3 -> the new frame starts with hex_out=3, and load_ack is high in the first cycle with idx==0.
REQ-032 Bench SHALL apply blink_in=4'b0001 and blank_in=4'b1000 -> digit 3 is never lit, and digit 0 is lit for 2 frames then dark for 2 frames, repeating.
REQ-033 Bench SHALL assert reset during idx==2 with a load pending -> an=1111 immediately (asynchronously), no load_ack is produced, and the scan restarts at idx 0.
